// File: rtl/csr_map_pkg.sv
// CSR window map and FSM encodings shared by the
// APB front-end and its address checker.
package csr_map_pkg;

    localparam logic [31:0] DEF_BASE_ADDR  = 32'hC0F16000;

    localparam logic [31:0] OFS_AXI_STAT   = 32'h0000_0000;
    localparam logic [31:0] OFS_APB_STAT   = 32'h0000_0004;
    localparam logic [31:0] OFS_SLV_CFG    = 32'h0000_0010;
    localparam logic [31:0] OFS_MST_CFG    = 32'h0000_0020;
    localparam logic [31:0] OFS_SAMPLE_CFG = 32'h0000_0B60;
    localparam logic [31:0] OFS_SAMPLE     = 32'h0000_0BAC;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

endpackage

// File: rtl/apb_csr_slave_if_if.sv
// APB4 completer-side bus bundle between the bridge
// master and the CSR front-end.
interface apb_csr_slave_if_if;
    import csr_map_pkg::*;

    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/csr_addr_check.sv
// Combinational legality check of a latched CSR access
// against the register map.
module csr_addr_check
    import csr_map_pkg::*;
(
    input  logic [31:0] offset,
    input  logic        pwrite,
    input  logic [3:0]  pstrb,
    output logic        legal,
    output logic        writable
);

    logic readable;
    logic aligned;

    assign aligned = (offset[1:0] == 2'b00);

    always_comb begin
        readable = 1'b0;
        writable = 1'b0;
        case (offset)
            OFS_AXI_STAT,
            OFS_APB_STAT,
            OFS_SAMPLE: begin
                readable = 1'b1;
            end
            OFS_SLV_CFG,
            OFS_MST_CFG,
            OFS_SAMPLE_CFG: begin
                readable = 1'b1;
                writable = 1'b1;
            end
            default: begin
                readable = 1'b0;
                writable = 1'b0;
            end
        endcase
    end

    // Writes must be full-word; read strobes do not affect legality.
    assign legal = aligned &
                   (pwrite ? (writable & (pstrb == 4'hF))
                           : readable);

endmodule

// File: rtl/apb_csr_slave_if.sv
// APB4 completer front-end: turns APB transfers into single-shot
// wen/ren strobes for the CSR block and returns rdata/pslverr.
module apb_csr_slave_if
    import csr_map_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                clk,
    input  logic                rst,
    apb_csr_slave_if_if.slave   apb,
    output logic                wen,
    output logic [31:0]         waddr,
    output logic [31:0]         wdata,
    output logic                ren,
    output logic [31:0]         raddr,
    input  logic [31:0]         rdata,
    output logic                prot_err
);

    localparam logic [3:0] WS = WAIT_STATES[3:0];

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [3:0]  strb_q;
    logic        wr_q;
    logic        pready_q;
    logic        pslverr_q;
    logic [31:0] prdata_q;
    logic [31:0] offset;
    logic        legal;
    logic        writable;
    logic        setup;
    logic        in_strobe;

    assign offset    = addr_q - BASE_ADDR;
    assign setup     = apb.psel & ~apb.penable;
    assign in_strobe = (state == ST_STROBE);

    csr_addr_check u_chk (
        .offset   (offset),
        .pwrite   (wr_q),
        .pstrb    (strb_q),
        .legal    (legal),
        .writable (writable)
    );

    // Moore strobes: one cycle in STROBE, mutually exclusive via wr_q.
    assign wen = in_strobe & wr_q & legal & writable;
    assign ren = in_strobe & ~wr_q & legal;

    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign apb.prdata  = prdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            strb_q    <= '0;
            wr_q      <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            waddr     <= '0;
            wdata     <= '0;
            raddr     <= '0;
            prot_err  <= 1'b0;
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prot_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (setup) begin
                        addr_q <= apb.paddr;
                        wr_q   <= apb.pwrite;
                        strb_q <= apb.pstrb;
                        cnt    <= WS;
                        state  <= ST_ACCESS;
                        if (apb.pwrite) begin
                            waddr <= apb.paddr;
                            wdata <= apb.pwdata;
                        end else begin
                            raddr    <= apb.paddr;
                            prot_err <= |apb.pstrb;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!(apb.psel && apb.penable)) begin
                        prot_err <= 1'b1;
                        state    <= ST_IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    pready_q  <= 1'b1;
                    pslverr_q <= ~legal;
                    if (!wr_q) begin
                        prdata_q <= legal ? rdata : 32'h0;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    // Master must hold psel until it sees pready.
                    if (!apb.psel) begin
                        prot_err <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_csr_slave_if.sv
// Scoreboard bench for apb_csr_slave_if: a WAIT_STATES=1 and a
// WAIT_STATES=0 instance share one APB master, selected by dsel.
module tb_apb_csr_slave_if;

    localparam logic [31:0] BASE = 32'hC0F16000;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        dsel;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] rdata;

    logic        wen_a, ren_a, perr_a;
    logic        wen_b, ren_b, perr_b;
    logic [31:0] waddr_a, wdata_a, raddr_a;
    logic [31:0] waddr_b, wdata_b, raddr_b;

    logic        pready, pslverr, wen, ren, prot_err;
    logic [31:0] prdata, waddr, wdata, raddr;

    int   vectors;
    int   miscompares;
    int   cyc;
    int   wen_cnt, ren_cnt, perr_cnt;
    int   wen_base, ren_base;
    exp_t sbq[$];

    apb_csr_slave_if_if a_if ();
    apb_csr_slave_if_if b_if ();

    assign a_if.psel    = psel & ~dsel;
    assign a_if.penable = penable;
    assign a_if.pwrite  = pwrite;
    assign a_if.paddr   = paddr;
    assign a_if.pwdata  = pwdata;
    assign a_if.pstrb   = pstrb;
    assign b_if.psel    = psel & dsel;
    assign b_if.penable = penable;
    assign b_if.pwrite  = pwrite;
    assign b_if.paddr   = paddr;
    assign b_if.pwdata  = pwdata;
    assign b_if.pstrb   = pstrb;

    assign pready   = dsel ? b_if.pready  : a_if.pready;
    assign pslverr  = dsel ? b_if.pslverr : a_if.pslverr;
    assign prdata   = dsel ? b_if.prdata  : a_if.prdata;
    assign wen      = dsel ? wen_b   : wen_a;
    assign ren      = dsel ? ren_b   : ren_a;
    assign waddr    = dsel ? waddr_b : waddr_a;
    assign wdata    = dsel ? wdata_b : wdata_a;
    assign raddr    = dsel ? raddr_b : raddr_a;
    assign prot_err = dsel ? perr_b  : perr_a;

    apb_csr_slave_if #(.BASE_ADDR(BASE), .WAIT_STATES(1)) dut_a (
        .clk(clk), .rst(rst), .apb(a_if.slave),
        .wen(wen_a), .waddr(waddr_a), .wdata(wdata_a),
        .ren(ren_a), .raddr(raddr_a), .rdata(rdata),
        .prot_err(perr_a)
    );

    apb_csr_slave_if #(.BASE_ADDR(BASE), .WAIT_STATES(0)) dut_b (
        .clk(clk), .rst(rst), .apb(b_if.slave),
        .wen(wen_b), .waddr(waddr_b), .wdata(wdata_b),
        .ren(ren_b), .raddr(raddr_b), .rdata(rdata),
        .prot_err(perr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_err(input logic wr,
                                       input logic [31:0] a,
                                       input logic [3:0] s);
        logic [31:0] rd_ok [6] = '{32'h000, 32'h004, 32'h010,
                                   32'h020, 32'hB60, 32'hBAC};
        logic [31:0] wr_ok [3] = '{32'h010, 32'h020, 32'hB60};
        logic [31:0] ofs;
        logic        r, w;
        ofs = a - BASE;
        r = 1'b0;
        w = 1'b0;
        foreach (rd_ok[i]) if (rd_ok[i] == ofs) r = 1'b1;
        foreach (wr_ok[i]) if (wr_ok[i] == ofs) w = 1'b1;
        if (a[1:0] != 2'b00) return 1'b1;
        if (!r) return 1'b1;
        if (wr && (!w || s != 4'hF)) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: strobe contents against the head entry, response on pready.
    always @(negedge clk) begin
        if (!rst) begin
            if (wen || ren) begin
                check("wen_ren_excl", {31'b0, wen & ren}, 32'd0);
                if (sbq.size() == 0) begin
                    check("strobe_unexp", 32'd1, 32'd0);
                end else if (wen) begin
                    check("wen_exp", 32'd1, {31'b0, sbq[0].wr & ~sbq[0].err});
                    check("waddr", waddr, sbq[0].addr);
                    check("wdata", wdata, sbq[0].wd);
                end else begin
                    check("ren_exp", 32'd1, {31'b0, ~sbq[0].wr & ~sbq[0].err});
                    check("raddr", raddr, sbq[0].addr);
                end
            end
            wen_cnt  += int'(wen);
            ren_cnt  += int'(ren);
            perr_cnt += int'(prot_err);
            if (pready) begin
                if (sbq.size() == 0) begin
                    check("pready_unexp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("pslverr", {31'b0, pslverr}, {31'b0, e.err});
                    check("latency", 32'(cyc), 32'(e.due));
                    if (!e.wr) check("prdata", prdata, e.rd);
                    check("wen_count", 32'(wen_cnt - wen_base),
                          {31'b0, e.wr & ~e.err});
                    check("ren_count", 32'(ren_cnt - ren_base),
                          {31'b0, ~e.wr & ~e.err});
                end
                wen_base = wen_cnt;
                ren_base = ren_cnt;
            end
        end
    end

    task automatic xfer(input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        bit   got;
        @(negedge clk);
        e.wr   = wr;
        e.addr = a;
        e.wd   = d;
        e.err  = model_err(wr, a, s);
        e.rd   = (wr || e.err) ? 32'h0 : rdata;
        e.due  = cyc + 1 + 2 + (dsel ? 0 : 1);
        sbq.push_back(e);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        pstrb   = s;
        @(negedge clk);
        penable = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("pready_timeout", 32'd0, 32'd1);
            if (sbq.size() != 0) void'(sbq.pop_front());
        end
        @(posedge clk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, w0, r0;
        logic [31:0] tbl [10] = '{32'h000, 32'h004, 32'h010, 32'h020,
                                  32'hB60, 32'hBAC, 32'h300, 32'h011,
                                  32'hFFC, 32'h008};
        vectors = 0; miscompares = 0; cyc = 0;
        wen_cnt = 0; ren_cnt = 0; perr_cnt = 0;
        wen_base = 0; ren_base = 0;
        dsel = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; rdata = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pready",   {31'b0, pready},   32'd0);
        check("rst_pslverr",  {31'b0, pslverr},  32'd0);
        check("rst_prot_err", {31'b0, prot_err}, 32'd0);
        check("rst_wen_ren",  {30'b0, wen, ren}, 32'd0);
        check("rst_prdata",   prdata, 32'd0);
        check("rst_waddr",    waddr,  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Legal write then legal read
        p0 = perr_cnt;
        xfer(1'b1, BASE + 32'h020, 32'h5, 4'hF);
        rdata = 32'h000A_BCDE;
        xfer(1'b0, BASE + 32'h000, 32'h0, 4'h0);
        check("perr_clean", 32'(perr_cnt - p0), 32'd0);

        // Illegal accesses
        xfer(1'b1, BASE + 32'h004, 32'hDEAD_BEEF, 4'hF);
        rdata = 32'h5555_AAAA;
        xfer(1'b0, BASE + 32'h300, 32'h0, 4'h0);
        xfer(1'b1, BASE + 32'h011, 32'h1234_5678, 4'hF);
        xfer(1'b1, BASE + 32'h010, 32'h0000_00FF, 4'h3);

        // More legal traffic, including a read with nonzero pstrb
        xfer(1'b1, BASE + 32'hB60, 32'hCAFE_F00D, 4'hF);
        rdata = 32'h8765_4321;
        xfer(1'b0, BASE + 32'hBAC, 32'h0, 4'h0);
        p0 = perr_cnt;
        rdata = 32'h0BAD_F00D;
        xfer(1'b0, BASE + 32'h010, 32'h0, 4'h1);
        check("perr_rd_strb", 32'(perr_cnt - p0), 32'd1);

        // psel dropped during ACCESS
        p0 = perr_cnt; w0 = wen_cnt; r0 = ren_cnt;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = BASE + 32'h010; pwdata = 32'h7777; pstrb = 4'hF;
        @(negedge clk);
        psel = 1'b0;
        repeat (4) @(negedge clk);
        check("drop_perr", 32'(perr_cnt - p0), 32'd1);
        check("drop_wen",  32'(wen_cnt - w0),  32'd0);
        check("drop_ren",  32'(ren_cnt - r0),  32'd0);
        xfer(1'b1, BASE + 32'h010, 32'h0000_1111, 4'hF);

        // Reset in ACCESS of a read
        r0 = ren_cnt;
        rdata = 32'h0000_1234;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
        paddr = BASE + 32'h000; pstrb = 4'h0;
        @(negedge clk);
        penable = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ctl", {27'b0, pready, pslverr, prot_err, wen, ren},
              32'd0);
        check("mid_rst_prdata", prdata, 32'd0);
        check("mid_rst_waddr",  waddr,  32'd0);
        check("mid_rst_raddr",  raddr,  32'd0);
        check("mid_rst_wdata",  wdata,  32'd0);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_rst_no_ren", 32'(ren_cnt - r0), 32'd0);

        // Zero wait states, back-to-back reads
        dsel = 1'b1;
        rdata = 32'h1111_0004;
        xfer(1'b0, BASE + 32'h004, 32'h0, 4'h0);
        rdata = 32'h2222_0B60;
        xfer(1'b0, BASE + 32'hB60, 32'h0, 4'h0);
        rdata = 32'h3333_0020;
        xfer(1'b0, BASE + 32'h020, 32'h0, 4'h0);

        // Mixed traffic from an address table on both instances
        for (int n = 0; n < 16; n++) begin
            logic        wr;
            logic [31:0] a;
            dsel  = n[0];
            wr    = 1'($urandom_range(0, 1));
            a     = BASE + tbl[$urandom_range(0, 9)];
            rdata = $urandom;
            xfer(wr, a, $urandom,
                 wr ? (($urandom_range(0, 3) == 0) ? 4'h7 : 4'hF) : 4'h0);
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
